// File: rtl/fcmp_unit.sv
// Two-stage FP32 compare/select unit (feq/flt/fle/fmin/fmax) with valid/ready flow control.
// Stage 1 holds the operation; stage 2 holds the registered result presented to the consumer.
module fcmp_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal
);
    localparam logic [2:0] OP_FEQ  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FLE  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;
    localparam logic [31:0] QNAN   = 32'h7fc00000;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] v);
        return v[30:23] == 8'h00;
    endfunction

    // Denormals collapse to a signed zero.
    function automatic logic [31:0] flush_dn(input logic [31:0] v);
        return is_zero(v) ? {v[31], 31'd0} : v;
    endfunction

    logic             s1_valid_r;
    logic [2:0]       s1_op_r;
    logic [31:0]      s1_x1_r;
    logic [31:0]      s1_x2_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic             s2_valid_r;
    logic [31:0]      y_r;
    logic [TAG_W-1:0] tag_r;
    logic             illegal_r;

    logic             adv1_s;
    logic             adv2_s;
    logic [31:0]      fa_s;
    logic [31:0]      fb_s;
    logic             na_s;
    logic             nb_s;
    logic             za_s;
    logic             zb_s;
    logic             sa_s;
    logic             sb_s;
    logic             eq_s;
    logic             lt_s;
    logic [31:0]      res_s;
    logic             ill_s;

    assign adv2_s    = !s2_valid_r || out_ready;
    assign adv1_s    = !s1_valid_r || adv2_s;
    assign in_ready  = adv1_s;
    assign out_valid = s2_valid_r;
    assign y         = y_r;
    assign tag_out   = tag_r;
    assign illegal   = illegal_r;

    // Operand classification and sign-magnitude ordering of the stage-1 operands.
    always_comb begin
        fa_s = flush_dn(s1_x1_r);
        fb_s = flush_dn(s1_x2_r);
        na_s = is_nan(s1_x1_r);
        nb_s = is_nan(s1_x2_r);
        za_s = is_zero(s1_x1_r);
        zb_s = is_zero(s1_x2_r);
        // Zeros count as non-negative so that +0 == -0.
        sa_s = fa_s[31] && !za_s;
        sb_s = fb_s[31] && !zb_s;
        eq_s = (sa_s == sb_s) && (fa_s[30:0] == fb_s[30:0]);
        if (sa_s != sb_s) begin
            lt_s = sa_s;
        end else if (!sa_s) begin
            lt_s = fa_s[30:0] < fb_s[30:0];
        end else begin
            lt_s = fa_s[30:0] > fb_s[30:0];
        end
    end

    // Result selection for the operation held in stage 1.
    always_comb begin
        res_s = 32'd0;
        ill_s = 1'b0;
        case (s1_op_r)
            OP_FEQ: res_s = {31'd0, !na_s && !nb_s && eq_s};
            OP_FLT: res_s = {31'd0, !na_s && !nb_s && lt_s};
            OP_FLE: res_s = {31'd0, !na_s && !nb_s && (lt_s || eq_s)};
            OP_FMIN, OP_FMAX: begin
                if (na_s && nb_s) begin
                    res_s = QNAN;
                end else if (na_s) begin
                    res_s = fb_s;
                end else if (nb_s) begin
                    res_s = fa_s;
                end else if (za_s && zb_s) begin
                    res_s = (s1_op_r == OP_FMIN) ? {fa_s[31] | fb_s[31], 31'd0}
                                                 : {fa_s[31] & fb_s[31], 31'd0};
                end else if (s1_op_r == OP_FMIN) begin
                    res_s = lt_s ? fa_s : fb_s;
                end else begin
                    res_s = lt_s ? fb_s : fa_s;
                end
            end
            default: begin
                res_s = 32'd0;
                ill_s = 1'b1;
            end
        endcase
    end

    // Pipeline registers: flush drops everything in flight, including an op offered that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'd0;
            s1_x1_r    <= 32'd0;
            s1_x2_r    <= 32'd0;
            s1_tag_r   <= '0;
            s2_valid_r <= 1'b0;
            y_r        <= 32'd0;
            tag_r      <= '0;
            illegal_r  <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (adv2_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    y_r       <= res_s;
                    tag_r     <= s1_tag_r;
                    illegal_r <= ill_s;
                end
            end
            if (adv1_s) begin
                s1_valid_r <= in_valid;
                if (in_valid) begin
                    s1_op_r  <= op;
                    s1_x1_r  <= x1;
                    s1_x2_r  <= x2;
                    s1_tag_r <= tag_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_fcmp_unit.sv
// Directed-vector bench for fcmp_unit: compares, ordering, min/max, NaN handling,
// back-to-back flow control under output stalls, flush, async reset and illegal ops.
module tb_fcmp_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [4:0]  tag_out;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    always #5 clk = ~clk;

    fcmp_unit #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x1(x1), .x2(x2), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .tag_out(tag_out), .illegal(illegal)
    );

    // Issue one op into an empty pipe with out_ready high; sample two cycles after acceptance.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, output logic [31:0] ry, output logic [4:0] rt,
                         output logic ri, output logic rv);
        @(posedge clk); #1;
        op = o; x1 = a; x2 = b; tag_in = t; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rv = out_valid; ry = y; rt = tag_out; ri = illegal;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; x1 = 32'd0; x2 = 32'd0; tag_in = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, y, tag_out, illegal, in_ready} !== {1'b0, 32'd0, 5'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset: got ov=%b y=%h tag=%h ill=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, y, tag_out, illegal, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_compare;
        vec_t tbl[$];
        logic [31:0] ry; logic [4:0] rt; logic ri, rv;
        tbl.push_back({3'd1, 32'h80000000, 32'h00000000, 32'h00000000});
        tbl.push_back({3'd0, 32'h80000000, 32'h00000000, 32'h00000001});
        tbl.push_back({3'd1, 32'hc0000000, 32'hbf800000, 32'h00000001});
        tbl.push_back({3'd2, 32'h3f800000, 32'h3f800000, 32'h00000001});
        tbl.push_back({3'd1, 32'h3f800000, 32'h3f800000, 32'h00000000});
        tbl.push_back({3'd1, 32'h3f800000, 32'hbf800000, 32'h00000000});
        tbl.push_back({3'd2, 32'hff800000, 32'hc0000000, 32'h00000001});
        tbl.push_back({3'd0, 32'h00000001, 32'h80000000, 32'h00000001});
        tbl.push_back({3'd1, 32'h7f800000, 32'h7f7fffff, 32'h00000000});
        tbl.push_back({3'd0, 32'h7f800000, 32'h7f800000, 32'h00000001});
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), ry, rt, ri, rv);
            vectors++;
            if ({rv, ry, rt, ri} !== {1'b1, tbl[i].e, 5'(i + 1), 1'b0}) begin
                miscompares++;
                $display("FAIL compare[%0d] op=%0d %h,%h: got v=%b y=%h tag=%h ill=%b, want y=%h tag=%h",
                         i, tbl[i].op, tbl[i].a, tbl[i].b, rv, ry, rt, ri, tbl[i].e, 5'(i + 1));
            end
        end
    endtask

    task automatic test_minmax;
        vec_t tbl[$];
        logic [31:0] ry; logic [4:0] rt; logic ri, rv;
        tbl.push_back({3'd3, 32'h00000000, 32'h80000000, 32'h80000000});
        tbl.push_back({3'd4, 32'h00000000, 32'h80000000, 32'h00000000});
        tbl.push_back({3'd3, 32'h00000001, 32'h3f800000, 32'h00000000});
        tbl.push_back({3'd4, 32'hc0000000, 32'hbf800000, 32'hbf800000});
        tbl.push_back({3'd3, 32'hc0000000, 32'hbf800000, 32'hc0000000});
        tbl.push_back({3'd4, 32'h80000005, 32'h00000000, 32'h00000000});
        tbl.push_back({3'd3, 32'h80000005, 32'h3f800000, 32'h80000000});
        tbl.push_back({3'd4, 32'hff800000, 32'h42000000, 32'h42000000});
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 16), ry, rt, ri, rv);
            vectors++;
            if ({rv, ry, rt, ri} !== {1'b1, tbl[i].e, 5'(i + 16), 1'b0}) begin
                miscompares++;
                $display("FAIL minmax[%0d] op=%0d %h,%h: got v=%b y=%h tag=%h ill=%b, want y=%h",
                         i, tbl[i].op, tbl[i].a, tbl[i].b, rv, ry, rt, ri, tbl[i].e);
            end
        end
    endtask

    task automatic test_nan;
        vec_t tbl[$];
        logic [31:0] ry; logic [4:0] rt; logic ri, rv;
        tbl.push_back({3'd1, 32'h7fc00001, 32'h3f800000, 32'h00000000});
        tbl.push_back({3'd2, 32'h7fc00001, 32'h3f800000, 32'h00000000});
        tbl.push_back({3'd0, 32'h7fc00001, 32'h3f800000, 32'h00000000});
        tbl.push_back({3'd0, 32'h7fc00001, 32'h7fc00001, 32'h00000000});
        tbl.push_back({3'd4, 32'h7fc00001, 32'h3f800000, 32'h3f800000});
        tbl.push_back({3'd3, 32'h7fc00001, 32'h3f800000, 32'h3f800000});
        tbl.push_back({3'd3, 32'h7fc00001, 32'hffc00000, 32'h7fc00000});
        tbl.push_back({3'd4, 32'h3f800000, 32'h7f800001, 32'h3f800000});
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 8), ry, rt, ri, rv);
            vectors++;
            if ({rv, ry, rt, ri} !== {1'b1, tbl[i].e, 5'(i + 8), 1'b0}) begin
                miscompares++;
                $display("FAIL nan[%0d] op=%0d %h,%h: got v=%b y=%h tag=%h ill=%b, want y=%h",
                         i, tbl[i].op, tbl[i].a, tbl[i].b, rv, ry, rt, ri, tbl[i].e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic m1 = 1'b0;
        logic m2 = 1'b0;
        logic exp_rdy, a1, a2;
        int issued = 0;
        int got = 0;
        logic [4:0] exp_q[$];
        logic [4:0] et;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc % 3 == 0);
            in_valid  = (issued < 8);
            op = 3'd3;
            x1 = 32'h3f800000 | 32'(issued + 1);
            x2 = 32'h40000000;
            tag_in = 5'(issued + 1);
            #1;
            exp_rdy = !(m1 && m2 && !out_ready);
            vectors++;
            if (in_ready !== exp_rdy || out_valid !== m2) begin
                miscompares++;
                $display("FAIL b2b_flow cyc=%0d: got rdy=%b ov=%b, want rdy=%b ov=%b",
                         cyc, in_ready, out_valid, exp_rdy, m2);
            end
            if (m2 && out_ready) begin
                et = exp_q.pop_front();
                got++;
                vectors++;
                if (tag_out !== et || y !== (32'h3f800000 | 32'(et)) || illegal !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_data cyc=%0d: got tag=%h y=%h, want tag=%h y=%h",
                             cyc, tag_out, y, et, 32'h3f800000 | 32'(et));
                end
            end
            if (in_valid && exp_rdy) begin
                exp_q.push_back(tag_in);
                issued++;
            end
            a2 = !m2 || out_ready;
            a1 = !m1 || a2;
            if (a2) m2 = m1;
            if (a1) m1 = in_valid;
        end
        vectors++;
        if (got != 8) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results, want 8", got);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Load two ops (tags t, t+1) while the output is stalled; both stages end up full.
    task automatic load_two(input logic [4:0] t);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        op = 3'd0; x1 = 32'h3f800000; x2 = 32'h3f800000; tag_in = t;
        @(posedge clk); #1;
        tag_in = t + 5'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_flush_reset;
        logic [31:0] ry; logic [4:0] rt; logic ri, rv;
        load_two(5'd20);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 32'd1 || tag_out !== 5'd20) begin
            miscompares++;
            $display("FAIL stall_full: got ov=%b rdy=%b y=%h tag=%h, want 1 0 1 14",
                     out_valid, in_ready, y, tag_out);
        end
        @(posedge clk); #1;
        vectors++;
        if (y !== 32'd1 || tag_out !== 5'd20 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_hold: got ov=%b y=%h tag=%h, want 1 1 14", out_valid, y, tag_out);
        end
        flush = 1'b1; in_valid = 1'b1; tag_in = 5'd30;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: got ov=%b, want 0", out_valid);
        end
        load_two(5'd24);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || y !== 32'd0 || tag_out !== 5'd0) begin
            miscompares++;
            $display("FAIL async_rst: got ov=%b y=%h tag=%h, want 0 0 0", out_valid, y, tag_out);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        do_op(3'b111, 32'h3f800000, 32'h40000000, 5'd7, ry, rt, ri, rv);
        vectors++;
        if ({rv, ry, rt, ri} !== {1'b1, 32'd0, 5'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL illegal: got v=%b y=%h tag=%h ill=%b, want 1 0 07 1", rv, ry, rt, ri);
        end
        do_op(3'b101, 32'h3f800000, 32'h3f800000, 5'd6, ry, rt, ri, rv);
        vectors++;
        if ({rv, ry, rt, ri} !== {1'b1, 32'd0, 5'd6, 1'b1}) begin
            miscompares++;
            $display("FAIL illegal_101: got v=%b y=%h tag=%h ill=%b, want 1 0 06 1", rv, ry, rt, ri);
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_minmax();
        test_nan();
        test_back_to_back();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
